// File: rtl/panel_sequencer.sv
// Front-panel controller: switch conditioning, run/stop/step clock sequencing and panel bus cycles.
// Optional feature macro: PANEL_AUTOINC_EN (ar_inc pulse after every panel bus cycle).
module panel_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MEM_CYCLES      = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic sw_lock,
    input  logic sw_start,
    input  logic sw_stop,
    input  logic sw_cont,
    input  logic sw_step,
    input  logic sw_dep_mem,
    input  logic sw_dep_io,
    input  logic sw_exam_mem,
    input  logic sw_exam_io,
    input  logic iend,
    output logic clken,
    output logic isrun,
    output logic isstop,
    output logic cpu_reset_req,
    output logic panel_req,
    output logic nmem,
    output logic nio,
    output logic nr,
    output logic nw,
    output logic ar_inc
);

    localparam int         NSW      = 8;
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0] STB_LAST = 5'(MEM_CYCLES);
    localparam logic [4:0] BUS_LAST = 5'(MEM_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_STOPPED, ST_RUN, ST_STOP_WAIT, ST_STEP_WAIT, ST_BUS
    } state_t;

    typedef enum logic [3:0] {
        CMD_NONE, CMD_STOP, CMD_START, CMD_CONT, CMD_STEP,
        CMD_DEP_MEM, CMD_DEP_IO, CMD_EXAM_MEM, CMD_EXAM_IO
    } cmd_t;

    logic [NSW-1:0] w_sw_raw;
    logic [NSW-1:0] r_sw_meta;
    logic [NSW-1:0] r_sw_sync;
    logic [NSW-1:0] w_sw_fall;
    logic           r_lock_meta, r_lock_sync;
    logic           r_iend_meta, r_iend_sync;

    state_t     r_state;
    cmd_t       w_cmd;
    logic       w_cmd_mem, w_cmd_dep;
    logic       r_armed;
    logic [4:0] r_bus_cnt;
    logic       r_bus_dep;
    logic       r_clken, r_isrun, r_isstop, r_cpu_reset_req;
    logic       r_panel_req, r_nmem, r_nio, r_nr, r_nw;

    // Bit order is also the same-cycle priority order, highest first.
    assign w_sw_raw = {sw_exam_io, sw_exam_mem, sw_dep_io, sw_dep_mem,
                       sw_step, sw_cont, sw_start, sw_stop};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sw_meta   <= '1;
            r_sw_sync   <= '1;
            r_lock_meta <= 1'b1;
            r_lock_sync <= 1'b1;
            r_iend_meta <= 1'b1;
            r_iend_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the chain really is two stages.
            r_sw_meta   <= w_sw_raw;
            r_sw_sync   <= r_sw_meta;
            r_lock_meta <= sw_lock;
            r_lock_sync <= r_lock_meta;
            r_iend_meta <= iend;
            r_iend_sync <= r_iend_meta;
        end
    end

    for (genvar g = 0; g < NSW; g++) begin : g_deb
        logic       r_deb;
        logic [7:0] r_cnt;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                r_deb <= 1'b1;
                r_cnt <= '0;
            end else if (r_sw_sync[g] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_deb <= r_sw_sync[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        // Press command fires in the same clock the debounced state falls.
        assign w_sw_fall[g] = r_deb & ~r_sw_sync[g] & (r_cnt == DEB_LAST);
    end

    always_comb begin
        // NOTE: default first so every path assigns w_cmd and no latch is inferred.
        w_cmd = CMD_NONE;
        if (!r_lock_sync) begin
            if      (w_sw_fall[0]) w_cmd = CMD_STOP;
            else if (w_sw_fall[1]) w_cmd = CMD_START;
            else if (w_sw_fall[2]) w_cmd = CMD_CONT;
            else if (w_sw_fall[3]) w_cmd = CMD_STEP;
            else if (w_sw_fall[4]) w_cmd = CMD_DEP_MEM;
            else if (w_sw_fall[5]) w_cmd = CMD_DEP_IO;
            else if (w_sw_fall[6]) w_cmd = CMD_EXAM_MEM;
            else if (w_sw_fall[7]) w_cmd = CMD_EXAM_IO;
        end
    end

    assign w_cmd_mem = (w_cmd == CMD_DEP_MEM) || (w_cmd == CMD_EXAM_MEM);
    assign w_cmd_dep = (w_cmd == CMD_DEP_MEM) || (w_cmd == CMD_DEP_IO);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state         <= ST_STOPPED;
            r_armed         <= 1'b0;
            r_bus_cnt       <= '0;
            r_bus_dep       <= 1'b0;
            r_clken         <= 1'b0;
            r_isrun         <= 1'b0;
            r_isstop        <= 1'b1;
            r_cpu_reset_req <= 1'b0;
            r_panel_req     <= 1'b0;
            r_nmem          <= 1'b1;
            r_nio           <= 1'b1;
            r_nr            <= 1'b1;
            r_nw            <= 1'b1;
        end else begin
            r_cpu_reset_req <= 1'b0;
            case (r_state)
                ST_STOPPED: begin
                    case (w_cmd)
                        CMD_START, CMD_CONT, CMD_STEP: begin
                            r_state         <= (w_cmd == CMD_STEP) ? ST_STEP_WAIT : ST_RUN;
                            r_armed         <= 1'b0;
                            r_cpu_reset_req <= (w_cmd == CMD_START);
                            r_clken         <= 1'b1;
                            r_isrun         <= 1'b1;
                            r_isstop        <= 1'b0;
                        end
                        CMD_DEP_MEM, CMD_DEP_IO, CMD_EXAM_MEM, CMD_EXAM_IO: begin
                            r_state     <= ST_BUS;
                            r_bus_cnt   <= '0;
                            r_bus_dep   <= w_cmd_dep;
                            r_panel_req <= 1'b1;
                            r_nmem      <= ~w_cmd_mem;
                            r_nio       <= w_cmd_mem;
                        end
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    if (w_cmd == CMD_STOP) begin
                        r_state <= ST_STOP_WAIT;
                        r_armed <= 1'b0;
                    end
                end
                ST_STOP_WAIT, ST_STEP_WAIT: begin
                    // Halt only on an iend fall seen after entry, i.e. a full instruction boundary.
                    if (r_iend_sync) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state  <= ST_STOPPED;
                        r_clken  <= 1'b0;
                        r_isrun  <= 1'b0;
                        r_isstop <= 1'b1;
                    end
                end
                ST_BUS: begin
                    r_bus_cnt <= r_bus_cnt + 5'd1;
                    if (r_bus_cnt == 5'd0) begin
                        r_nw <= ~r_bus_dep;
                        r_nr <= r_bus_dep;
                    end else if (r_bus_cnt == STB_LAST) begin
                        r_nw <= 1'b1;
                        r_nr <= 1'b1;
                    end else if (r_bus_cnt == BUS_LAST) begin
                        r_state     <= ST_STOPPED;
                        r_panel_req <= 1'b0;
                        r_nmem      <= 1'b1;
                        r_nio       <= 1'b1;
                    end
                end
                default: r_state <= ST_STOPPED;
            endcase
        end
    end

`ifdef PANEL_AUTOINC_EN
    logic r_ar_inc;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_ar_inc <= 1'b0;
        else         r_ar_inc <= (r_state == ST_BUS) && (r_bus_cnt == BUS_LAST);
    end

    assign ar_inc = r_ar_inc;
`else
    assign ar_inc = 1'b0;
`endif

    assign clken         = r_clken;
    assign isrun         = r_isrun;
    assign isstop        = r_isstop;
    assign cpu_reset_req = r_cpu_reset_req;
    assign panel_req     = r_panel_req;
    assign nmem          = r_nmem;
    assign nio           = r_nio;
    assign nr            = r_nr;
    assign nw            = r_nw;

endmodule

// File: doc/panel_sequencer.md
Name: panel_sequencer

Overview:
Synchronous front-panel controller. Conditions raw panel switches: synchronise, debounce, edge-detect. Sequences the processor clock enable (run / stop-at-boundary / single-step) from the uPC instruction-end signal. Runs panel deposit/examine bus cycles while the processor is stopped. Sits between the switch bank and the clock generator / bus drivers; replaces ad-hoc switch decoding.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable clk samples before a debounced switch changes state (2..255)
MEM_CYCLES, 4, clocks the read/write strobe is held low during a panel bus cycle (1..15)

Ports:
clk  in  1  free-running system clock (not the gated CPU clock)
nreset  in  1  asynchronous active-low reset
sw_lock  in  1  1 = panel locked (all commands ignored)
sw_start, sw_stop, sw_cont, sw_step  in  1 each  raw switches, active-low
sw_dep_mem, sw_dep_io, sw_exam_mem, sw_exam_io  in  1 each  raw switches, active-low
iend  in  1  active-low end-of-instruction from uPC counter, asynchronous to clk
clken  out  1  enable to clock generator
isrun, isstop  out  1 each  status lamps
cpu_reset_req  out  1  one-clk pulse, issued by START
panel_req  out  1  panel owns the bus
nmem, nio, nr, nw  out  1 each  active-low bus space / strobe
ar_inc  out  1  one-clk address-register increment pulse (see Optional Feature)

Behaviour:
- Reset: clk and nreset are as fixed above (one clock; reset asynchronous, active-low). All outputs take reset values immediately: clken=0, isrun=0, isstop=1, cpu_reset_req=0, panel_req=0, nmem=nio=nr=nw=1, ar_inc=0. FSM=STOPPED. Debounced states=released (1). Counters=0.
- Switch path: 2-flop synchroniser. Debounce counter resets whenever the synced value equals the debounced state. Debounced state flips once the value has differed for DEBOUNCE_CYCLES consecutive clocks.
- Command pulse: one clk on each debounced 1->0 edge. Release edges produce nothing. Holding a switch yields exactly one command.
- Same-cycle priority: stop > start > cont > step > dep_mem > dep_io > exam_mem > exam_io. Lower-priority pulses in that cycle are discarded, not queued.
- sw_lock=1: all commands discarded. An operation already in progress completes.
- iend: 2-flop synchronised before use.
- FSM states and transitions:
  STOPPED: clken=0, isstop=1.
    start -> RUN, with cpu_reset_req high for the first RUN clock.
    cont -> RUN.
    step -> STEP_WAIT.
    dep_* / exam_* -> BUS.
    stop -> ignored.
  RUN: clken=1, isrun=1. stop -> STOP_WAIT. All other commands ignored.
  STOP_WAIT / STEP_WAIT: clken=1, isrun=1. Clear armed flag on entry. Set armed when synced iend=1. When armed and synced iend=0 -> STOPPED; clken drops in that same clock. A stop during STEP_WAIT is ignored (step already halts).
  BUS: cycle counter c=0..MEM_CYCLES+1, panel_req=1 throughout.
    c=0: nmem (mem cmd) or nio (io cmd) low; nr and nw high.
    c=1..MEM_CYCLES: additionally nw low (dep) or nr low (exam).
    c=MEM_CYCLES+1: strobe high, space still low.
    Then -> STOPPED with all bus outputs released.
    Total panel_req width = MEM_CYCLES+2 clocks.
- Status: exactly one of isrun/isstop is high at all times; both are registered.
- Reset mid-BUS or mid-STEP_WAIT: immediate abort to reset values. No strobe glitch low after nreset falls.

Optional Feature:
PANEL_AUTOINC_EN
- Defined: ar_inc pulses high for exactly one clock in the first STOPPED clock after any BUS cycle, so repeated deposits/examines walk through memory.
- Undefined: ar_inc is constant 0, with no increment logic. The address register is advanced only by external means.

Test Plan:
- Reset, then unlock (sw_lock=0), DEBOUNCE_CYCLES=4. Pulse sw_start low for 3 clks -> no command. Hold low for 10 clks -> after 2+4 clks: RUN, clken=1, cpu_reset_req high for exactly 1 clk.
- In RUN, iend toggling low every 10 clks. Press sw_stop -> clken stays 1 until the next synced iend low, then clken=0, isstop=1. Repeat 4x sw_step -> each step yields exactly one iend-high-to-low interval of clken=1.
- MEM_CYCLES=3, STOPPED. Press sw_dep_mem -> panel_req high 5 clks, nmem low 5 clks, nw low on clks 2-4, nr stays 1. sw_exam_io -> same pattern on nio/nr.
- sw_stop and sw_step asserted same clk while STOPPED -> stop wins (ignored); state stays STOPPED, clken=0. sw_lock=1 then sw_cont -> no change.
- nreset low at BUS c=2 -> nw, nmem, panel_req return to 1 within the same timestep; FSM=STOPPED after release.
- PANEL_AUTOINC_EN defined: two consecutive deposits -> two single-clock ar_inc pulses. Undefined: ar_inc never 1.
